// File: rtl/dma_sched_pkg.sv
// -----------------------------------------------------------------------------
// dma_sched_pkg
// Shared definitions for the DMA read-command scheduler.
//   - sched_state_e : scheduler FSM states (IDLE, ISSUE)
//   - DEF_*         : default parameter values for dma_rd_sched
//   - slice_lsb()   : LSB position of element idx in a packed array of w-bit fields
//   - id_width()    : index width for an N-entry vector (never below 1)
// No ports (package).
// -----------------------------------------------------------------------------
package dma_sched_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } sched_state_e;

   localparam int DEF_NUM_CH   = 8;
   localparam int DEF_ADDR_W   = 32;
   localparam int DEF_LEN_W    = 4;
   localparam int DEF_MAX_OUTS = 4;

   function automatic int slice_lsb(input int idx, input int w);
      return idx * w;
   endfunction

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dma_rr_arb.sv
// -----------------------------------------------------------------------------
// dma_rr_arb
// Combinational round-robin arbiter. The search starts at ptr and wraps; the
// first requesting index at or after ptr wins.
// Ports:
//   req  in  N    request vector
//   ptr  in  IW   search start index
//   gnt  out N    one-hot grant (zero when no request)
//   idx  out IW   index of the granted request
//   any  out 1    at least one request present
// -----------------------------------------------------------------------------
module dma_rr_arb
   import dma_sched_pkg::*;
#(
   parameter int N = DEF_NUM_CH,
   localparam int IW = id_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   always_comb begin : search
      logic [IW-1:0] k;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      k   = '0;
      for (int i = 0; i < N; i++) begin
         k = IW'((int'(ptr) + i) % N);
         if (!any && req[k]) begin
            any    = 1'b1;
            gnt[k] = 1'b1;
            idx    = k;
         end
      end
   end

endmodule

// File: rtl/dma_rd_sched.sv
// -----------------------------------------------------------------------------
// dma_rd_sched
// Schedules AXI read-burst commands from NUM_CH DMA channels onto one AR port.
// Round-robin arbitration, at most one burst in flight per channel, and at
// most MAX_OUTS bursts in flight overall.
//
// Optional feature: define DMA_SCHED_PRIO_EN for two-level strict priority
// (eligible ch_prio=1 channels first, round-robin within each level, one
// shared pointer). Without it ch_prio is ignored.
//
// Handshake: ar_valid rises only with a registered command and is held, with
// ar_id/ar_addr/ar_len stable, until the cycle in which ar_ready is high; that
// cycle is the transfer, and ch_gnt[ar_id] is high in exactly that cycle.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   ch_req     in  NUM_CH   level request, held until ch_gnt
//   ch_addr    in  NUM_CH*ADDR_W packed start addresses
//   ch_len     in  NUM_CH*LEN_W  packed ARLEN values
//   ch_prio    in  NUM_CH   high-priority flag (priority build only)
//   ch_gnt     out NUM_CH   one-hot, AR handshake cycle
//   ar_valid/ar_ready/ar_id/ar_addr/ar_len   AXI AR channel 0
//   r_done     in  1        last read beat accepted
//   r_done_id  in  ID_W     RID of that beat
//   ch_busy    out NUM_CH   burst in flight per channel
//   outs_cnt   out          bursts in flight
//   err_unexp  out 1        sticky: completion for a channel not in flight
//   idle       out 1        no request, nothing in flight, FSM idle
// -----------------------------------------------------------------------------
module dma_rd_sched
   import dma_sched_pkg::*;
#(
   parameter int NUM_CH   = DEF_NUM_CH,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int LEN_W    = DEF_LEN_W,
   parameter int MAX_OUTS = DEF_MAX_OUTS,
   localparam int ID_W    = id_width(NUM_CH),
   localparam int CNT_W   = $clog2(MAX_OUTS + 1)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_CH-1:0]        ch_req,
   input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
   input  logic [NUM_CH*LEN_W-1:0]  ch_len,
   input  logic [NUM_CH-1:0]        ch_prio,
   output logic [NUM_CH-1:0]        ch_gnt,
   output logic                     ar_valid,
   input  logic                     ar_ready,
   output logic [ID_W-1:0]          ar_id,
   output logic [ADDR_W-1:0]        ar_addr,
   output logic [LEN_W-1:0]         ar_len,
   input  logic                     r_done,
   input  logic [ID_W-1:0]          r_done_id,
   output logic [NUM_CH-1:0]        ch_busy,
   output logic [CNT_W-1:0]         outs_cnt,
   output logic                     err_unexp,
   output logic                     idle
);

   sched_state_e        state_q, state_n;
   logic [ID_W-1:0]     rr_ptr;
   logic [NUM_CH-1:0]   elig;
   logic                can_sel;
   logic                sel_any;
   logic [ID_W-1:0]     sel_idx;
   logic [NUM_CH-1:0]   sel_gnt;
   logic [ADDR_W-1:0]   sel_addr;
   logic [LEN_W-1:0]    sel_len;
   logic                load;
   logic                hs;
   logic                done_hit;
   logic [NUM_CH-1:0]   busy_n;
   logic [CNT_W-1:0]    cnt_n;
   logic                err_n;

   assign can_sel = (outs_cnt < CNT_W'(MAX_OUTS));
   assign elig    = can_sel ? (ch_req & ~ch_busy) : '0;

`ifdef DMA_SCHED_PRIO_EN
   logic [NUM_CH-1:0] hi_gnt, lo_gnt;
   logic [ID_W-1:0]   hi_idx, lo_idx;
   logic              hi_any, lo_any;

   dma_rr_arb #(.N(NUM_CH)) u_arb_hi (
      .req (elig & ch_prio),
      .ptr (rr_ptr),
      .gnt (hi_gnt),
      .idx (hi_idx),
      .any (hi_any)
   );

   dma_rr_arb #(.N(NUM_CH)) u_arb_lo (
      .req (elig & ~ch_prio),
      .ptr (rr_ptr),
      .gnt (lo_gnt),
      .idx (lo_idx),
      .any (lo_any)
   );

   // Any eligible high-priority channel shadows the whole low level.
   assign sel_any = hi_any | lo_any;
   assign sel_idx = hi_any ? hi_idx : lo_idx;
   assign sel_gnt = hi_any ? hi_gnt : lo_gnt;
`else
   logic unused_prio;
   assign unused_prio = ^ch_prio;

   dma_rr_arb #(.N(NUM_CH)) u_arb (
      .req (elig),
      .ptr (rr_ptr),
      .gnt (sel_gnt),
      .idx (sel_idx),
      .any (sel_any)
   );
`endif

   // AND-OR payload mux driven by the one-hot grant.
   always_comb begin
      sel_addr = '0;
      sel_len  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (sel_gnt[i]) begin
            sel_addr = sel_addr | ch_addr[slice_lsb(i, ADDR_W) +: ADDR_W];
            sel_len  = sel_len  | ch_len[slice_lsb(i, LEN_W) +: LEN_W];
         end
      end
   end

   assign ar_valid = (state_q == ISSUE);
   assign hs       = ar_valid & ar_ready;

   always_comb begin
      ch_gnt = '0;
      if (hs) ch_gnt[ar_id] = 1'b1;
   end

   // FSM next state
   always_comb begin
      state_n = state_q;
      load    = 1'b0;
      case (state_q)
         IDLE: begin
            if (sel_any) begin
               load    = 1'b1;
               state_n = ISSUE;
            end
         end
         ISSUE: begin
            if (ar_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // In-flight bookkeeping. The handshake set is applied after the completion
   // clear so that a same-id collision leaves the channel busy.
   assign done_hit = r_done & ch_busy[r_done_id];

   always_comb begin
      busy_n = ch_busy;
      cnt_n  = outs_cnt;
      err_n  = err_unexp;
      if (done_hit) busy_n[r_done_id] = 1'b0;
      if (r_done && !ch_busy[r_done_id]) err_n = 1'b1;
      if (hs) busy_n[ar_id] = 1'b1;
      if (hs && !done_hit)      cnt_n = outs_cnt + 1'b1;
      else if (!hs && done_hit) cnt_n = outs_cnt - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         ar_id     <= '0;
         ar_addr   <= '0;
         ar_len    <= '0;
         rr_ptr    <= '0;
         ch_busy   <= '0;
         outs_cnt  <= '0;
         err_unexp <= 1'b0;
      end else begin
         state_q   <= state_n;
         ch_busy   <= busy_n;
         outs_cnt  <= cnt_n;
         err_unexp <= err_n;
         if (load) begin
            ar_id   <= sel_idx;
            ar_addr <= sel_addr;
            ar_len  <= sel_len;
         end
         if (hs) begin
            rr_ptr <= (ar_id == ID_W'(NUM_CH - 1)) ? '0 : ar_id + 1'b1;
         end
      end
   end

   assign idle = (ch_req == '0) && (outs_cnt == '0) && (state_q == IDLE);

endmodule
